piso_frame_controller: RTL and testbench

//  Sequencing controller for the PISO serial datapath: accepts WIDTH-bit words by valid/ready, generates the baud tick
//  and drives shift-register load/shift strobes plus a line-select code (idle/start/data/parity/stop) to the tx mux.

---
 rtl/piso_frame_controller.sv | 221 ++++++++++++++++++++++
 tb/tb_piso_frame_controller.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/piso_frame_controller.sv
// piso_frame_controller: burst/frame sequencer for the PISO tx path (valid/ready word intake, baud divider, line select).
// Build option: define PISO_TWO_STOP_EN for two stop-bit periods per frame; the default build sends one stop bit.
module piso_frame_controller #(
    parameter int WIDTH           = 8,
    parameter int CLK_FREQ_HZ     = 1_843_200,
    parameter int MIN_NUM_PACKETS = 1,
    parameter int MAX_NUM_PACKETS = 1000
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    input  logic [1:0]       cfg_baud,
    input  logic             cfg_parity_en,
    input  logic [9:0]       cfg_num_packets,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             sr_load,
    output logic             sr_shift,
    output logic [1:0]       line_sel,
    output logic             parity_bit,
    output logic             bit_tick,
    output logic             busy,
    output logic             done
);

    localparam int DIV_9600   = CLK_FREQ_HZ / 9600;
    localparam int DIV_19200  = CLK_FREQ_HZ / 19200;
    localparam int DIV_38400  = CLK_FREQ_HZ / 38400;
    localparam int DIV_115200 = CLK_FREQ_HZ / 115200;
    localparam int DIV_W      = (DIV_9600 > 1) ? $clog2(DIV_9600) : 1;
    localparam int IDX_W      = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    localparam logic [9:0] NUM_MIN = 10'(MIN_NUM_PACKETS);
    localparam logic [9:0] NUM_MAX = 10'(MAX_NUM_PACKETS);

    localparam logic [1:0] LINE_MARK   = 2'b00;
    localparam logic [1:0] LINE_START  = 2'b01;
    localparam logic [1:0] LINE_DATA   = 2'b10;
    localparam logic [1:0] LINE_PARITY = 2'b11;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WAIT,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } state_t;

    state_t state, state_nxt;

    logic [1:0]       baud_q;
    logic             parity_en_q;
    logic [9:0]       pkt_cnt;
    logic             abort_pending;
    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_max;
    logic [IDX_W-1:0] bit_idx;
`ifdef PISO_TWO_STOP_EN
    logic             stop_idx;
`endif

    logic in_frame;
    logic accept;
    logic abort_eff;
    logic last_stop;
    logic burst_end;

    function automatic logic [9:0] clamp_num(input logic [9:0] n);
        if (n < NUM_MIN)
            return NUM_MIN;
        else if (n > NUM_MAX)
            return NUM_MAX;
        else
            return n;
    endfunction

    always_comb begin
        div_max = '0;
        case (baud_q)
            2'b00:   div_max = DIV_W'(DIV_9600 - 1);
            2'b01:   div_max = DIV_W'(DIV_19200 - 1);
            2'b10:   div_max = DIV_W'(DIV_38400 - 1);
            default: div_max = DIV_W'(DIV_115200 - 1);
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n)
            state <= ST_IDLE;
        else
            state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE: begin
                if (start)
                    state_nxt = ST_WAIT;
            end
            ST_WAIT: begin
                if (accept)
                    state_nxt = ST_START;
                else if (abort_pending)
                    state_nxt = ST_IDLE;
            end
            ST_START: begin
                if (bit_tick)
                    state_nxt = ST_DATA;
            end
            ST_DATA: begin
                if (bit_tick && bit_idx == IDX_W'(WIDTH - 1))
                    state_nxt = parity_en_q ? ST_PARITY : ST_STOP;
            end
            ST_PARITY: begin
                if (bit_tick)
                    state_nxt = ST_STOP;
            end
            ST_STOP: begin
                if (last_stop)
                    state_nxt = burst_end ? ST_IDLE : ST_WAIT;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Output logic; done and the busy drop share the final cycle of the burst
    always_comb begin
        in_frame   = 1'b0;
        data_ready = 1'b0;
        accept     = 1'b0;
        bit_tick   = 1'b0;
        sr_load    = 1'b0;
        sr_shift   = 1'b0;
        last_stop  = 1'b0;
        abort_eff  = abort_pending | abort;
        burst_end  = 1'b0;
        busy       = 1'b0;
        done       = 1'b0;
        line_sel   = LINE_MARK;

        in_frame   = (state == ST_START) || (state == ST_DATA) ||
                     (state == ST_PARITY) || (state == ST_STOP);
        data_ready = (state == ST_WAIT) && !abort_pending;
        accept     = data_ready && data_valid;
        sr_load    = accept;
        bit_tick   = in_frame && (div_cnt == div_max);
        sr_shift   = (state == ST_DATA) && bit_tick;
`ifdef PISO_TWO_STOP_EN
        last_stop  = (state == ST_STOP) && bit_tick && stop_idx;
`else
        last_stop  = (state == ST_STOP) && bit_tick;
`endif
        burst_end  = (last_stop && ((pkt_cnt == '0) || abort_eff)) ||
                     ((state == ST_WAIT) && abort_pending);
        done       = burst_end;
        busy       = (state != ST_IDLE) && !burst_end;

        case (state)
            ST_START:  line_sel = LINE_START;
            ST_DATA:   line_sel = LINE_DATA;
            ST_PARITY: line_sel = LINE_PARITY;
            default:   line_sel = LINE_MARK;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            baud_q        <= '0;
            parity_en_q   <= 1'b0;
            pkt_cnt       <= '0;
            abort_pending <= 1'b0;
            div_cnt       <= '0;
            bit_idx       <= '0;
            parity_bit    <= 1'b0;
        end else begin
            if (state == ST_IDLE && start) begin
                baud_q      <= cfg_baud;
                parity_en_q <= cfg_parity_en;
                pkt_cnt     <= clamp_num(cfg_num_packets);
            end else if (accept && pkt_cnt != '0) begin
                pkt_cnt     <= pkt_cnt - 10'd1;
            end

            if (accept)
                parity_bit <= ^data_in;

            if (state == ST_IDLE || state_nxt == ST_IDLE)
                abort_pending <= 1'b0;
            else if (busy && abort)
                abort_pending <= 1'b1;

            if (in_frame && !bit_tick)
                div_cnt <= div_cnt + DIV_W'(1);
            else
                div_cnt <= '0;

            if (state != ST_DATA)
                bit_idx <= '0;
            else if (bit_tick)
                bit_idx <= bit_idx + IDX_W'(1);
        end
    end

`ifdef PISO_TWO_STOP_EN
    always_ff @(posedge clk) begin
        if (!rst_n)
            stop_idx <= 1'b0;
        else if (state != ST_STOP)
            stop_idx <= 1'b0;
        else if (bit_tick)
            stop_idx <= ~stop_idx;
    end
`endif

endmodule

// File: tb/tb_piso_frame_controller.sv
// Scoreboard bench for piso_frame_controller: a line/shift monitor rebuilds each frame and tasks compare it to queued expectations.
// A second instance with a fast clock setting covers the 1000-frame clamp within a short run.
`timescale 1ns/1ps
module tb_piso_frame_controller;

`ifdef PISO_TWO_STOP_EN
    localparam int XSTOP = 1;
`else
    localparam int XSTOP = 0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n = 1'b0, start = 1'b0, abort = 1'b0, cfg_parity_en = 1'b0, data_valid = 1'b0;
    logic [1:0] cfg_baud = 2'b00;
    logic [9:0] cfg_num_packets = 10'd0;
    logic [7:0] data_in = 8'h00;
    logic       data_ready, sr_load, sr_shift, parity_bit, bit_tick, busy, done;
    logic [1:0] line_sel;

    logic       f_start = 1'b0, f_valid = 1'b0;
    logic [9:0] f_num = 10'd0;
    logic       f_ready, f_load, f_shift, f_par, f_tick, f_busy, f_done;
    logic [1:0] f_line;

    piso_frame_controller #(.WIDTH(8), .CLK_FREQ_HZ(1_843_200), .MIN_NUM_PACKETS(1), .MAX_NUM_PACKETS(1000)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cfg_baud(cfg_baud),
        .cfg_parity_en(cfg_parity_en), .cfg_num_packets(cfg_num_packets), .data_in(data_in),
        .data_valid(data_valid), .data_ready(data_ready), .sr_load(sr_load), .sr_shift(sr_shift),
        .line_sel(line_sel), .parity_bit(parity_bit), .bit_tick(bit_tick), .busy(busy), .done(done)
    );

    piso_frame_controller #(.WIDTH(8), .CLK_FREQ_HZ(230_400), .MIN_NUM_PACKETS(1), .MAX_NUM_PACKETS(1000)) dut_fast (
        .clk(clk), .rst_n(rst_n), .start(f_start), .abort(1'b0), .cfg_baud(2'b11),
        .cfg_parity_en(1'b0), .cfg_num_packets(f_num), .data_in(8'h5A),
        .data_valid(f_valid), .data_ready(f_ready), .sr_load(f_load), .sr_shift(f_shift),
        .line_sel(f_line), .parity_bit(f_par), .bit_tick(f_tick), .busy(f_busy), .done(f_done)
    );

    typedef struct {
        logic [7:0] word;
        logic       par;
        int acc, last_tick, nshift, nticks, start_len, par_len;
        int first_shift, last_shift, gap_min, gap_max;
    } frame_t;

    typedef struct {
        logic [7:0] word;
        logic       par;
    } exp_t;

    int     vec = 0, miss = 0, cyc = 0;
    frame_t cur;
    bit     open = 1'b0;
    logic [7:0] sr_m;
    int     mon_gap;
    frame_t rx_q[$];
    exp_t   exp_q[$];
    int     done_q[$];
    logic   busy_at_done[$];
    int     f_loads = 0, f_dones = 0;

    always @(posedge clk) cyc++;

    // Rebuilds frames from the strobes, with a local shift-register model fed by sr_load/sr_shift
    always @(negedge clk) begin
        if (!rst_n) begin
            open = 1'b0;
        end else begin
            if (open) begin
                if (line_sel == 2'b01) cur.start_len++;
                if (line_sel == 2'b11) cur.par_len++;
                if (cyc == cur.acc + 1) cur.par = parity_bit;
                if (bit_tick) begin
                    cur.nticks++;
                    cur.last_tick = cyc;
                end
                if (sr_shift) begin
                    if (cur.nshift == 0) begin
                        cur.first_shift = cyc;
                    end else begin
                        mon_gap = cyc - cur.last_shift;
                        if (mon_gap < cur.gap_min) cur.gap_min = mon_gap;
                        if (mon_gap > cur.gap_max) cur.gap_max = mon_gap;
                    end
                    cur.last_shift = cyc;
                    cur.word = {sr_m[0], cur.word[7:1]};
                    sr_m = {1'b0, sr_m[7:1]};
                    cur.nshift++;
                end
            end
            if (done) begin
                done_q.push_back(cyc);
                busy_at_done.push_back(busy);
                if (open) begin
                    rx_q.push_back(cur);
                    open = 1'b0;
                end
            end
            if (sr_load) begin
                if (open) rx_q.push_back(cur);
                cur.word = 8'h00; cur.par = 1'b0; cur.acc = cyc; cur.last_tick = 0;
                cur.nshift = 0; cur.nticks = 0; cur.start_len = 0; cur.par_len = 0;
                cur.first_shift = 0; cur.last_shift = 0; cur.gap_min = 1 << 30; cur.gap_max = 0;
                sr_m = data_in;
                open = 1'b1;
            end
        end
        if (f_load) f_loads++;
        if (f_done) f_dones++;
    end

    task automatic start_burst(input logic [1:0] baud, input logic par, input logic [9:0] num);
        @(posedge clk); #1;
        cfg_baud = baud; cfg_parity_en = par; cfg_num_packets = num; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic send_word(input logic [7:0] w, input int limit, output int acc, output bit ok);
        exp_t e;
        e.word = w;
        e.par  = ^w;
        exp_q.push_back(e);
        data_in = w; data_valid = 1'b1; ok = 1'b0; acc = -1;
        for (int i = 0; i < limit; i++) begin
            @(negedge clk);
            if (data_ready) begin
                acc = cyc;
                ok  = 1'b1;
                break;
            end
        end
        @(posedge clk); #1;
        data_valid = 1'b0;
    endtask

    task automatic wait_done(input int n0, input int limit, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < limit; i++) begin
            @(posedge clk); #1;
            if (done_q.size() > n0) begin
                ok = 1'b1;
                break;
            end
        end
    endtask

    task automatic wait_until(input int target);
        while (cyc < target) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0; start = 1'b1; data_valid = 1'b1; data_in = 8'hFF; cfg_num_packets = 10'd4;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if ({data_ready, sr_load, sr_shift, line_sel, parity_bit, bit_tick, busy, done} !== 9'h0) begin
                miss++; $display("FAIL reset_outputs cycle %0d: got %b want 0", i,
                    {data_ready, sr_load, sr_shift, line_sel, parity_bit, bit_tick, busy, done});
            end
        end
        @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        vec++; if ({data_ready, busy, done, line_sel} !== 5'h0) begin
            miss++; $display("FAIL reset_release_idle: got %b want 0", {data_ready, busy, done, line_sel});
        end
        @(posedge clk); #1; start = 1'b0; data_valid = 1'b0;
        @(negedge clk);
        vec++; if (busy !== 1'b1) begin miss++; $display("FAIL reset_then_start_busy: got %b want 1", busy); end
        @(posedge clk); #1; rst_n = 1'b0;
        @(posedge clk); #1; @(posedge clk); #1; rst_n = 1'b1;
        @(negedge clk);
        vec++; if (busy !== 1'b0) begin miss++; $display("FAIL reset_rearm_busy: got %b want 0", busy); end
    endtask

    task automatic test_fast_no_parity;
        int acc, len, n0;
        bit ok;
        frame_t f;
        exp_t e;
        n0  = done_q.size();
        len = (10 + XSTOP) * 16;
        start_burst(2'b11, 1'b0, 10'd1);
        send_word(8'hA5, 10, acc, ok);
        vec++; if (!ok) begin miss++; $display("FAIL fast_accept: got no ready want ready"); end
        wait_until(acc + len);
        start = 1'b1;
        @(posedge clk); #1; start = 1'b0;
        wait_done(n0, 50, ok);
        vec++; if (!ok) begin miss++; $display("FAIL fast_done_seen: got none want done"); end
        if (ok) begin
            vec++; if (done_q[$] !== acc + len) begin miss++; $display("FAIL fast_done_time: got %0d want %0d", done_q[$] - acc, len); end
            vec++; if (busy_at_done[$] !== 1'b0) begin miss++; $display("FAIL fast_busy_at_done: got %b want 0", busy_at_done[$]); end
        end
        vec++; if (rx_q.size() !== 1) begin
            miss++; $display("FAIL fast_frames: got %0d want 1", rx_q.size());
        end else begin
            f = rx_q.pop_front(); e = exp_q.pop_front();
            vec++; if (f.word !== e.word) begin miss++; $display("FAIL fast_word: got %h want %h", f.word, e.word); end
            vec++; if (f.par !== 1'b0) begin miss++; $display("FAIL fast_parity: got %b want 0", f.par); end
            vec++; if (f.start_len !== 16) begin miss++; $display("FAIL fast_start_len: got %0d want 16", f.start_len); end
            vec++; if (f.nshift !== 8) begin miss++; $display("FAIL fast_nshift: got %0d want 8", f.nshift); end
            vec++; if (f.first_shift - acc !== 32) begin miss++; $display("FAIL fast_first_shift: got %0d want 32", f.first_shift - acc); end
            vec++; if (f.gap_min !== 16 || f.gap_max !== 16) begin miss++; $display("FAIL fast_shift_gap: got %0d..%0d want 16", f.gap_min, f.gap_max); end
            vec++; if (f.nticks !== 10 + XSTOP) begin miss++; $display("FAIL fast_ticks: got %0d want %0d", f.nticks, 10 + XSTOP); end
            vec++; if (f.last_tick - acc !== len) begin miss++; $display("FAIL fast_frame_len: got %0d want %0d", f.last_tick - acc, len); end
            vec++; if (f.par_len !== 0) begin miss++; $display("FAIL fast_no_parity_bit: got %0d want 0", f.par_len); end
        end
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            vec++; if ({busy, line_sel} !== 3'b000) begin miss++; $display("FAIL fast_start_on_done_ignored: got %b want 000", {busy, line_sel}); end
        end
    endtask

    task automatic test_parity_slow;
        int acc1, acc2, len, n0;
        bit ok1, ok2, ok;
        frame_t f;
        exp_t e;
        n0  = done_q.size();
        len = (11 + XSTOP) * 192;
        start_burst(2'b00, 1'b1, 10'd2);
        send_word(8'h07, 10, acc1, ok1);
        send_word(8'h03, 3000, acc2, ok2);
        vec++; if (!(ok1 && ok2)) begin miss++; $display("FAIL par_accepts: got %b%b want 11", ok1, ok2); end
        vec++; if (acc2 - acc1 !== len + 1) begin miss++; $display("FAIL par_second_accept: got %0d want %0d", acc2 - acc1, len + 1); end
        wait_done(n0, 3000, ok);
        vec++; if (!ok || done_q[$] !== acc2 + len) begin miss++; $display("FAIL par_done_time: got %0d want %0d", ok ? done_q[$] - acc2 : -1, len); end
        repeat (4) @(posedge clk);
        #1;
        vec++; if (done_q.size() !== n0 + 1) begin miss++; $display("FAIL par_done_count: got %0d want 1", done_q.size() - n0); end
        for (int k = 0; k < 2; k++) begin
            vec++; if (rx_q.size() == 0 || exp_q.size() == 0) begin
                miss++; $display("FAIL par_frame%0d_present: got none want frame", k);
            end else begin
                f = rx_q.pop_front(); e = exp_q.pop_front();
                vec++; if (f.word !== e.word) begin miss++; $display("FAIL par_word%0d: got %h want %h", k, f.word, e.word); end
                vec++; if (f.par !== (k == 0 ? 1'b1 : 1'b0)) begin miss++; $display("FAIL par_bit%0d: got %b want %b", k, f.par, k == 0); end
                vec++; if (f.par_len !== 192) begin miss++; $display("FAIL par_len%0d: got %0d want 192", k, f.par_len); end
                vec++; if (f.last_tick - f.acc !== len) begin miss++; $display("FAIL par_frame_len%0d: got %0d want %0d", k, f.last_tick - f.acc, len); end
            end
        end
    endtask

    task automatic test_clamp_zero;
        int acc, len, n0, loads;
        bit ok;
        n0  = done_q.size();
        len = (10 + XSTOP) * 16;
        start_burst(2'b11, 1'b0, 10'd0);
        send_word(8'h3C, 10, acc, ok);
        wait_done(n0, 400, ok);
        vec++; if (!ok || done_q[$] !== acc + len) begin miss++; $display("FAIL clamp0_done_time: got %0d want %0d", ok ? done_q[$] - acc : -1, len); end
        data_valid = 1'b1; loads = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sr_load) loads++;
        end
        @(posedge clk); #1; data_valid = 1'b0;
        vec++; if (loads !== 0) begin miss++; $display("FAIL clamp0_extra_loads: got %0d want 0", loads); end
        vec++; if (rx_q.size() !== 1) begin miss++; $display("FAIL clamp0_frames: got %0d want 1", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_abort_mid;
        int acc1, acc2, len, n0, loads;
        bit ok1, ok2, ok;
        frame_t f;
        n0  = done_q.size();
        len = (10 + XSTOP) * 16;
        start_burst(2'b11, 1'b0, 10'd5);
        send_word(8'h11, 10, acc1, ok1);
        send_word(8'h22, 400, acc2, ok2);
        vec++; if (!(ok1 && ok2)) begin miss++; $display("FAIL abort_accepts: got %b%b want 11", ok1, ok2); end
        wait_until(acc2 + 50);
        abort = 1'b1; start = 1'b1; cfg_baud = 2'b00; cfg_num_packets = 10'd7;
        @(posedge clk); #1; abort = 1'b0; start = 1'b0;
        wait_done(n0, 400, ok);
        vec++; if (!ok || done_q[$] !== acc2 + len) begin miss++; $display("FAIL abort_done_time: got %0d want %0d", ok ? done_q[$] - acc2 : -1, len); end
        @(negedge clk);
        vec++; if ({data_ready, busy} !== 2'b00) begin miss++; $display("FAIL abort_after_done: got %b want 00", {data_ready, busy}); end
        vec++; if (rx_q.size() !== 2) begin
            miss++; $display("FAIL abort_frames: got %0d want 2", rx_q.size());
        end else begin
            void'(rx_q.pop_front());
            f = rx_q.pop_front();
            vec++; if (f.word !== 8'h22 || f.last_tick - f.acc !== len) begin
                miss++; $display("FAIL abort_frame2: got %h/%0d want 22/%0d", f.word, f.last_tick - f.acc, len);
            end
        end
        data_valid = 1'b1; loads = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (sr_load) loads++;
        end
        @(posedge clk); #1; data_valid = 1'b0;
        vec++; if (loads !== 0) begin miss++; $display("FAIL abort_no_more_loads: got %0d want 0", loads); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_abort_wait;
        int acc, len, n0, t;
        bit ok;
        len = (10 + XSTOP) * 16;
        n0 = done_q.size();
        start_burst(2'b11, 1'b0, 10'd3);
        abort = 1'b1;
        send_word(8'h5C, 10, acc, ok);
        abort = 1'b0;
        wait_done(n0, 400, ok);
        vec++; if (!ok || done_q[$] !== acc + len) begin miss++; $display("FAIL abort_accept_same_edge_done: got %0d want %0d", ok ? done_q[$] - acc : -1, len); end
        vec++; if (rx_q.size() !== 1 || rx_q[0].word !== 8'h5C) begin miss++; $display("FAIL abort_accept_same_edge_frame: got %0d frames want 1 of 5c", rx_q.size()); end
        rx_q.delete(); exp_q.delete();

        n0 = done_q.size();
        start_burst(2'b11, 1'b0, 10'd3);
        send_word(8'hC3, 10, acc, ok);
        wait_until(acc + len + 1);
        @(negedge clk);
        vec++; if ({data_ready, line_sel} !== 3'b100) begin miss++; $display("FAIL wait_idle_line: got %b want 100", {data_ready, line_sel}); end
        @(posedge clk); #1; abort = 1'b1; t = cyc;
        @(posedge clk); #1; abort = 1'b0;
        wait_done(n0, 50, ok);
        vec++; if (!ok || done_q[$] !== t + 1) begin miss++; $display("FAIL abort_in_wait_done: got %0d want %0d", ok ? done_q[$] - t : -1, 1); end
        vec++; if (rx_q.size() !== 1) begin miss++; $display("FAIL abort_in_wait_frames: got %0d want 1", rx_q.size()); end
        rx_q.delete(); exp_q.delete();
    endtask

    task automatic test_mid_reset;
        int acc, n0;
        bit ok;
        n0 = done_q.size();
        start_burst(2'b11, 1'b0, 10'd2);
        send_word(8'h98, 10, acc, ok);
        wait_until(acc + 40);
        rst_n = 1'b0;
        @(posedge clk); #1;
        @(negedge clk);
        vec++; if ({data_ready, sr_load, sr_shift, line_sel, parity_bit, bit_tick, busy, done} !== 9'h0) begin
            miss++; $display("FAIL midreset_outputs: got %b want 0",
                {data_ready, sr_load, sr_shift, line_sel, parity_bit, bit_tick, busy, done});
        end
        @(posedge clk); #1; rst_n = 1'b1;
        void'(exp_q.pop_back());
        repeat (200) @(posedge clk);
        #1;
        vec++; if (done_q.size() !== n0) begin miss++; $display("FAIL midreset_no_done: got %0d want 0", done_q.size() - n0); end
        vec++; if (rx_q.size() !== 0 || busy !== 1'b0) begin miss++; $display("FAIL midreset_dropped: got %0d frames busy %b want 0/0", rx_q.size(), busy); end
    endtask

    task automatic test_max_clamp;
        int l0, d0;
        bit ok;
        l0 = f_loads; d0 = f_dones; ok = 1'b0;
        f_valid = 1'b1; f_num = 10'd1023; f_start = 1'b1;
        @(posedge clk); #1; f_start = 1'b0;
        for (int i = 0; i < 40000; i++) begin
            @(posedge clk); #1;
            if (f_dones > d0) begin
                ok = 1'b1;
                break;
            end
        end
        f_valid = 1'b0;
        vec++; if (!ok) begin miss++; $display("FAIL max_clamp_done: got none want done"); end
        vec++; if (f_loads - l0 !== 1000) begin miss++; $display("FAIL max_clamp_loads: got %0d want 1000", f_loads - l0); end
        @(negedge clk);
        vec++; if (f_busy !== 1'b0 || f_dones - d0 !== 1) begin miss++; $display("FAIL max_clamp_end: got busy %b dones %0d want 0/1", f_busy, f_dones - d0); end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fast_no_parity();
        test_parity_slow();
        test_clamp_zero();
        test_abort_mid();
        test_abort_wait();
        test_mid_reset();
        test_max_clamp();
        $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
        $finish;
    end

endmodule
